// File: rtl/grey_conv_arbiter.sv
// Round-robin arbiter sharing one Gray-to-binary converter among N requesters.
// Optional even-parity output enabled by defining GREY_ARB_PARITY_EN.
//
// state | meaning
// IDLE  | searching for a requester from ptr upward, grant strobed combinationally
// CONV  | converting the captured Gray word, result registered on exit
// DONE  | result held on out_* until out_ready
module grey_conv_arbiter #(
    parameter int WIDTH = 4,
    parameter int N     = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [N-1:0]           req_valid,
    input  logic [N*WIDTH-1:0]     req_gray,
    output logic [N-1:0]           req_ready,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [WIDTH-1:0]       out_bin,
    output logic [$clog2(N)-1:0]   out_id
`ifdef GREY_ARB_PARITY_EN
    ,
    output logic                   out_par
`endif
);

    localparam int IDW = $clog2(N);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CONV = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state;
    logic [IDW-1:0]   ptr;
    logic [IDW-1:0]   cap_id;
    logic [WIDTH-1:0] cap_gray;
    logic [IDW-1:0]   win_id;
    logic             win_hit;
    logic [IDW-1:0]   idx;
    logic [WIDTH-1:0] conv_bin;

    function automatic logic [WIDTH-1:0] g2b(input logic [WIDTH-1:0] g);
        logic [WIDTH-1:0] b;
        b = '0;
        b[WIDTH-1] = g[WIDTH-1];
        for (int k = WIDTH - 2; k >= 0; k--) begin
            b[k] = b[k+1] ^ g[k];
        end
        return b;
    endfunction

    // Scan offsets high to low so the nearest set bit at/after ptr wins; N is a power of two so the add wraps.
    always_comb begin
        win_id  = ptr;
        win_hit = 1'b0;
        idx     = '0;
        for (int k = N - 1; k >= 0; k--) begin
            idx = ptr + IDW'(k);
            if (req_valid[idx]) begin
                win_id  = idx;
                win_hit = 1'b1;
            end
        end
    end

    always_comb begin
        req_ready = '0;
        if (state == IDLE && !rst && win_hit) begin
            req_ready[win_id] = 1'b1;
        end
    end

    assign conv_bin = g2b(cap_gray);

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            ptr       <= '0;
            cap_id    <= '0;
            cap_gray  <= '0;
            out_valid <= 1'b0;
            out_bin   <= '0;
            out_id    <= '0;
`ifdef GREY_ARB_PARITY_EN
            out_par   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (win_hit) begin
                        cap_gray <= req_gray[int'(win_id)*WIDTH +: WIDTH];
                        cap_id   <= win_id;
                        ptr      <= win_id + IDW'(1);
                        state    <= CONV;
                    end
                end
                CONV: begin
                    out_bin   <= conv_bin;
                    out_id    <= cap_id;
                    out_valid <= 1'b1;
`ifdef GREY_ARB_PARITY_EN
                    out_par   <= ^conv_bin;
`endif
                    state     <= DONE;
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/grey_conv_arbiter.md
# grey_conv_arbiter

- Round-robin arbiter and sequencer that shares one Gray-to-binary conversion datapath among N requesters.
- Each requester presents a WIDTH-bit Gray code with a valid/ready handshake.
- The block grants one requester, converts its code, and presents the binary result with the requester ID on a single valid/ready output port.
- It sits between the Gray-coded sources (position encoders, async-FIFO pointers) and downstream binary logic.

## Interface
- WIDTH, 4, Gray/binary word width (≥2)
- N, 4, number of requesters (power of two, 2..8)
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- req_valid  input  N  requester i has a Gray word pending
- req_gray  input  N*WIDTH  requester i's Gray word in bits [i*WIDTH +: WIDTH]
- req_ready  output  N  one-hot accept strobe; requester i's word is taken on a clk edge where req_valid[i] & req_ready[i]
- out_valid  output  1  out_bin/out_id hold a completed conversion
- out_ready  input  1  downstream accepts the result this cycle
- out_bin  output  WIDTH  binary result
- out_id  output  log2(N)  index of the requester that produced out_bin
- out_par  output  1  even parity of out_bin (present only with GREY_ARB_PARITY_EN)

## Operation
- Conversion:
  - out_bin[WIDTH-1] = g[WIDTH-1].
  - out_bin[k] = out_bin[k+1] ^ g[k], for k descending.
  - Computed from a captured register, never from live req_gray.
- FSM states IDLE, CONV, DONE.
- IDLE:
  - If no req_valid bit is set, stay in IDLE with req_ready = 0.
  - Otherwise, the round-robin winner is the first set req_valid bit at or after pointer ptr, searching upward with wrap-around.
  - req_ready[winner] = 1 combinationally in that same cycle.
  - On the edge: capture the Gray word and winner index, set ptr = (winner+1) mod N, go to CONV.
- CONV: register the converted value into out_bin and the ID into out_id, set out_valid = 1, go to DONE.
- DONE:
  - out_valid = 1 with out_bin/out_id stable.
  - Stay in DONE while out_ready = 0.
  - On an edge with out_ready = 1: clear out_valid and go to IDLE.
- req_ready is zero in CONV and DONE, so at most one word is in flight.
- A requester that drops req_valid before being granted is simply skipped. The handshake rule requires holding, but the block does not check it.
- Reset values:
  - state = IDLE, ptr = 0, out_valid = 0.
  - out_bin = 0, out_id = 0, out_par = 0.
  - req_ready = 0.
- Reset mid-operation: an in-flight word in CONV or DONE is discarded with no output, and the next grant starts from requester 0.

## Timing
- Acceptance edge at the end of cycle T. CONV occupies T+1. out_valid is high from cycle T+2.
- Latency from accept to out_valid is 2 cycles.
- The earliest next accept is the cycle after the out_valid/out_ready handshake. Peak throughput is one word per 3 cycles.
- Simultaneous requests are granted in ptr order only. Starvation-free: any held request is served within N grants.
- out_ready high in IDLE or CONV is ignored.
- rst takes priority over every other event on the same edge.

## Configuration
- GREY_ARB_PARITY_EN defined:
  - out_par is a port.
  - It is registered in CONV alongside out_bin as the XOR-reduction of the converted value.
  - It holds with out_bin and resets to 0.
- GREY_ARB_PARITY_EN undefined: the out_par port and its register are absent. All other behaviour is identical.

## Test plan
- Reset:
  - Assert rst for 2 cycles with all req_valid = 1.
  - Expect out_valid = 0, req_ready = 0, out_bin = 0, out_id = 0 throughout.
  - After release, the first grant goes to requester 0.
- Single conversion:
  - Requester 1 presents 4'b1101.
  - Expect req_ready = 4'b0010 in the accept cycle, then out_valid two cycles later with out_bin = 4'b1001 and out_id = 1.
  - With the macro defined, expect out_par = 0.
- Exhaustive sweep: requester 2 presents gray = i ^ (i>>1) for i = 0..15 with out_ready held high. Expect out_bin = i and out_id = 2 every time, one result every 3 cycles.
- Round-robin:
  - All four req_valid held high with out_ready = 1.
  - Expect grant order 0,1,2,3,0,1.
  - Drop req_valid[1] and expect 2,3,0,2.
- Backpressure:
  - Hold out_ready = 0 for 10 cycles in DONE.
  - Expect out_valid, out_bin and out_id to stay stable and req_ready = 0.
  - When out_ready rises for one cycle, expect out_valid to drop on the next edge.
- Reset mid-flight: assert rst during CONV. Expect no out_valid afterwards, and the next accept grants requester 0 regardless of the prior ptr.
